// File: rtl/str_acq_gate_pkg.sv
// Shared definitions for the acquisition gate: state encoding and default counter width.
package str_acq_pkg;

   localparam int ACQ_CW = 32;

   typedef logic [2:0] acq_state_t;

   localparam acq_state_t ST_IDLE = 3'd0;
   localparam acq_state_t ST_PRE  = 3'd1;
   localparam acq_state_t ST_ARM  = 3'd2;
   localparam acq_state_t ST_PST  = 3'd3;
   localparam acq_state_t ST_STP  = 3'd4;

   function automatic logic acq_active(input acq_state_t s);
      return s != ST_IDLE;
   endfunction

endpackage

// File: rtl/str_acq_gate_reg.sv
// One-stage AXI4-stream register slice (data, last, valid/ready) with synchronous clear.
module str_reg #(
   parameter int DW = 16
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          clr_i,
   input  logic [DW-1:0] s_tdata_i,
   input  logic          s_tlast_i,
   input  logic          s_tvalid_i,
   output logic          s_tready_o,
   output logic [DW-1:0] m_tdata_o,
   output logic          m_tlast_o,
   output logic          m_tvalid_o,
   input  logic          m_tready_i
);

   logic [DW-1:0] data_q, data_d;
   logic          last_q, last_d;
   logic          vld_q,  vld_d;

   // Slot is free when empty or being drained this cycle.
   assign s_tready_o = ~vld_q | m_tready_i;

   always_comb begin
      data_d = data_q;
      last_d = last_q;
      vld_d  = vld_q;
      if (s_tready_o) begin
         vld_d = s_tvalid_i;
         if (s_tvalid_i) begin
            data_d = s_tdata_i;
            last_d = s_tlast_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         data_q <= '0;
         last_q <= 1'b0;
         vld_q  <= 1'b0;
      end else if (clr_i) begin
         data_q <= '0;
         last_q <= 1'b0;
         vld_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         last_q <= last_d;
         vld_q  <= vld_d;
      end
   end

   assign m_tdata_o  = data_q;
   assign m_tlast_o  = last_q;
   assign m_tvalid_o = vld_q;

endmodule

// File: rtl/str_acq_gate.sv
// Acquisition gate: forwards ADC samples through pre-trigger, armed and post-trigger phases,
// closing each acquisition with TLAST and reporting sample/trigger indices.
module str_acq_gate
   import str_acq_pkg::*;
#(
   parameter int DW = 16,
   parameter int CW = ACQ_CW
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          ctl_rst,
   input  logic          ctl_start,
   input  logic          ctl_stop,
   input  logic [CW-1:0] cfg_pre,
   input  logic [CW-1:0] cfg_pst,
   input  logic          trg,
   input  logic [DW-1:0] sti_tdata,
   input  logic          sti_tvalid,
   output logic          sti_tready,
   output logic [DW-1:0] sto_tdata,
   output logic          sto_tvalid,
   input  logic          sto_tready,
   output logic          sto_tlast,
   output logic          sts_run,
   output logic          sts_trg,
   output logic [CW-1:0] sts_cnt,
   output logic [CW-1:0] sts_trg_cnt
);

   localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

   acq_state_t    state_q, state_d;
   logic [CW-1:0] pre_q,   pre_d;
   logic [CW-1:0] pst_q,   pst_d;
   logic [CW-1:0] ph_q,    ph_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [CW-1:0] tcnt_q,  tcnt_d;
   logic          trg_q,   trg_d;

   logic acc;
   logic fwd;
   logic last;

   assign acc = sti_tvalid & sti_tready;

   // ph_q counts samples within the current phase; compares against cfg-1 so it never overflows.
   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      pst_d   = pst_q;
      ph_d    = ph_q;
      cnt_d   = cnt_q;
      tcnt_d  = tcnt_q;
      trg_d   = trg_q;
      fwd     = 1'b0;
      last    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (ctl_start) begin
               pre_d   = cfg_pre;
               pst_d   = cfg_pst;
               ph_d    = '0;
               cnt_d   = '0;
               trg_d   = 1'b0;
               state_d = (cfg_pre == '0) ? ST_ARM : ST_PRE;
            end
         end
         ST_PRE: begin
            if (acc) begin
               fwd = 1'b1;
               if (ctl_stop) begin
                  last    = 1'b1;
                  state_d = ST_IDLE;
               end else if (ph_q == pre_q - ONE) begin
                  ph_d    = '0;
                  state_d = ST_ARM;
               end else begin
                  ph_d = ph_q + ONE;
               end
            end else if (ctl_stop) begin
               state_d = ST_STP;
            end
         end
         ST_ARM: begin
            if (acc) begin
               fwd = 1'b1;
               if (ctl_stop) begin
                  last    = 1'b1;
                  state_d = ST_IDLE;
               end else if (trg) begin
                  trg_d  = 1'b1;
                  tcnt_d = cnt_q;
                  if (pst_q <= ONE) begin
                     last    = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     ph_d    = ONE;
                     state_d = ST_PST;
                  end
               end
            end else if (ctl_stop) begin
               state_d = ST_STP;
            end
         end
         ST_PST: begin
            if (acc) begin
               fwd = 1'b1;
               if (ctl_stop || (ph_q == pst_q - ONE)) begin
                  last    = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  ph_d = ph_q + ONE;
               end
            end else if (ctl_stop) begin
               state_d = ST_STP;
            end
         end
         ST_STP: begin
            if (acc) begin
               fwd     = 1'b1;
               last    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (fwd) cnt_d = cnt_q + ONE;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         pre_q   <= '0;
         pst_q   <= '0;
         ph_q    <= '0;
         cnt_q   <= '0;
         tcnt_q  <= '0;
         trg_q   <= 1'b0;
      end else if (ctl_rst) begin
         state_q <= ST_IDLE;
         pre_q   <= '0;
         pst_q   <= '0;
         ph_q    <= '0;
         cnt_q   <= '0;
         tcnt_q  <= '0;
         trg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         pst_q   <= pst_d;
         ph_q    <= ph_d;
         cnt_q   <= cnt_d;
         tcnt_q  <= tcnt_d;
         trg_q   <= trg_d;
      end
   end

   // Beats accepted in IDLE are simply not presented to the slice, so they are dropped.
   str_reg #(
      .DW (DW)
   ) u_reg (
      .clk_i      (clk),
      .rstn_i     (rstn),
      .clr_i      (ctl_rst),
      .s_tdata_i  (sti_tdata),
      .s_tlast_i  (last),
      .s_tvalid_i (fwd),
      .s_tready_o (sti_tready),
      .m_tdata_o  (sto_tdata),
      .m_tlast_o  (sto_tlast),
      .m_tvalid_o (sto_tvalid),
      .m_tready_i (sto_tready)
   );

   assign sts_run     = acq_active(state_q);
   assign sts_trg     = trg_q;
   assign sts_cnt     = cnt_q;
   assign sts_trg_cnt = tcnt_q;

endmodule

// File: tb/tb_str_acq_gate.sv
// Scoreboard bench for str_acq_gate: acquisition-level reference model, decoupled output monitor.
module tb_str_acq_gate;

   localparam int DW = 16;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          ctl_rst = 1'b0;
   logic          ctl_start = 1'b0;
   logic          ctl_stop = 1'b0;
   logic [CW-1:0] cfg_pre = '0;
   logic [CW-1:0] cfg_pst = '0;
   logic          trg = 1'b0;
   logic [DW-1:0] sti_tdata = '0;
   logic          sti_tvalid = 1'b0;
   logic          sti_tready;
   logic [DW-1:0] sto_tdata;
   logic          sto_tvalid;
   logic          sto_tready = 1'b0;
   logic          sto_tlast;
   logic          sts_run;
   logic          sts_trg;
   logic [CW-1:0] sts_cnt;
   logic [CW-1:0] sts_trg_cnt;

   str_acq_gate #(.DW(DW), .CW(CW)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .ctl_rst     (ctl_rst),
      .ctl_start   (ctl_start),
      .ctl_stop    (ctl_stop),
      .cfg_pre     (cfg_pre),
      .cfg_pst     (cfg_pst),
      .trg         (trg),
      .sti_tdata   (sti_tdata),
      .sti_tvalid  (sti_tvalid),
      .sti_tready  (sti_tready),
      .sto_tdata   (sto_tdata),
      .sto_tvalid  (sto_tvalid),
      .sto_tready  (sto_tready),
      .sto_tlast   (sto_tlast),
      .sts_run     (sts_run),
      .sts_trg     (sts_trg),
      .sts_cnt     (sts_cnt),
      .sts_trg_cnt (sts_trg_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ob = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: acquisition described by beat counts, not by the RTL phase machine.
   bit             m_run = 0;
   bit             m_trg = 0;
   bit             m_stop = 0;
   bit             m_acc = 0;
   longint         m_n = 0;
   longint         m_post = 0;
   longint         m_pre = 0;
   longint         m_pst = 0;
   longint         m_trgcnt = 0;
   logic [DW:0]    expq[$];

   always @(posedge clk) begin : model
      bit acc;
      bit lst;
      acc = sti_tvalid && sti_tready;
      if (!rstn || ctl_rst) begin
         m_run = 0; m_trg = 0; m_stop = 0; m_acc = 0;
         m_n = 0; m_post = 0; m_trgcnt = 0;
         expq.delete();
      end else begin
         m_acc = acc;
         if (!m_run) begin
            if (ctl_start) begin
               m_run = 1; m_stop = 0; m_trg = 0; m_n = 0; m_post = 0;
               m_pre = longint'(cfg_pre);
               m_pst = longint'(cfg_pst);
            end
         end else begin
            if (ctl_stop) m_stop = 1;
            if (acc) begin
               lst = 0;
               if (m_stop) begin
                  lst = 1;
               end else if (m_trg) begin
                  m_post++;
                  lst = (m_post >= m_pst);
               end else if (m_n >= m_pre && trg) begin
                  m_trg = 1;
                  m_trgcnt = m_n;
                  m_post = 1;
                  lst = (m_pst <= 1);
               end
               expq.push_back({lst, sti_tdata});
               m_n++;
               if (lst) m_run = 0;
            end
         end
      end
   end

   always @(negedge clk) begin : monitor
      logic [DW:0] e;
      if (rstn) begin
         if (sto_tvalid && sto_tready) begin
            ob++;
            chk("beat_expected", 64'(expq.size() != 0), 64'd1);
            if (expq.size() != 0) begin
               e = expq.pop_front();
               chk("beat_data", 64'(sto_tdata), 64'(e[DW-1:0]));
               chk("beat_last", 64'(sto_tlast), 64'(e[DW]));
            end
         end
         chk("sts_run", 64'(sts_run), 64'(m_run));
         chk("sts_cnt", 64'(sts_cnt), 64'(m_n[31:0]));
         chk("sts_trg", 64'(sts_trg), 64'(m_trg));
         chk("sts_trg_cnt", 64'(sts_trg_cnt), 64'(m_trgcnt[31:0]));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (m_acc) sti_tdata = DW'($urandom);
   endtask

   task automatic pulse_start(input int pre, input int pst);
      cfg_pre = CW'(pre);
      cfg_pst = CW'(pst);
      ctl_start = 1'b1;
      step();
      ctl_start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (sts_run && n < budget) begin
         step();
         n++;
      end
      chk("idle_reached", 64'(sts_run), 64'd0);
   endtask

   task automatic drain();
      sti_tvalid = 1'b0;
      trg = 1'b0;
      ctl_stop = 1'b0;
      ctl_start = 1'b0;
      sto_tready = 1'b1;
      repeat (4) step();
      chk("queue_drained", 64'(expq.size()), 64'd0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_tvalid"}, 64'(sto_tvalid), 64'd0);
      chk({tag, "_tlast"}, 64'(sto_tlast), 64'd0);
      chk({tag, "_tdata"}, 64'(sto_tdata), 64'd0);
      chk({tag, "_run"}, 64'(sts_run), 64'd0);
      chk({tag, "_trg"}, 64'(sts_trg), 64'd0);
      chk({tag, "_cnt"}, 64'(sts_cnt), 64'd0);
      chk({tag, "_trg_cnt"}, 64'(sts_trg_cnt), 64'd0);
   endtask

   initial begin
      int ob0;
      int n;
      #1;
      chk_zero("reset");
      repeat (2) step();
      rstn = 1'b1;
      step();

      // Pre 4, post 3, trigger on 7th beat.
      ob0 = ob;
      sti_tvalid = 1'b1; sto_tready = 1'b1;
      pulse_start(4, 3);
      for (int k = 1; k <= 12; k++) begin
         trg = (k == 7);
         step();
      end
      drain();
      chk("t1_beats", 64'(ob - ob0), 64'd9);
      chk("t1_trg_cnt", 64'(sts_trg_cnt), 64'd6);
      chk("t1_cnt", 64'(sts_cnt), 64'd9);

      // No pre-trigger, single post sample.
      ob0 = ob;
      sti_tvalid = 1'b1;
      pulse_start(0, 1);
      trg = 1'b1;
      step();
      trg = 1'b0;
      repeat (3) step();
      drain();
      chk("t2_beats", 64'(ob - ob0), 64'd1);
      chk("t2_trg_cnt", 64'(sts_trg_cnt), 64'd0);
      chk("t2_trg", 64'(sts_trg), 64'd1);

      // Triggers during pre-trigger phase are ignored.
      ob0 = ob;
      sti_tvalid = 1'b1;
      pulse_start(8, 2);
      for (int k = 1; k <= 14; k++) begin
         trg = (k == 2 || k == 5 || k == 8 || k == 11);
         step();
      end
      drain();
      chk("t3_trg_cnt", 64'(sts_trg_cnt), 64'd10);
      chk("t3_beats", 64'(ob - ob0), 64'd12);

      // Random backpressure and valid gaps.
      sti_tvalid = 1'b1;
      pulse_start(16, 16);
      n = 0;
      while (sts_run && n < 3000) begin
         sti_tvalid = ($urandom_range(0, 99) < 80);
         sto_tready = ($urandom_range(0, 99) < 50);
         trg = ($urandom_range(0, 99) < 5);
         step();
         n++;
      end
      chk("t4_idle", 64'(sts_run), 64'd0);
      drain();

      // Stop in ARM without data, start ignored while running, then stop ignored in IDLE.
      ob0 = ob;
      sti_tvalid = 1'b1;
      pulse_start(2, 5);
      repeat (3) step();
      sti_tvalid = 1'b0; ctl_stop = 1'b1; ctl_start = 1'b1; cfg_pre = 0; cfg_pst = 1;
      step();
      ctl_stop = 1'b0; ctl_start = 1'b0;
      step();
      chk("t5_run_stp", 64'(sts_run), 64'd1);
      sti_tvalid = 1'b1; trg = 1'b1;
      step();
      trg = 1'b0; sti_tvalid = 1'b0;
      step();
      chk("t5_trg", 64'(sts_trg), 64'd0);
      chk("t5_run", 64'(sts_run), 64'd0);
      ctl_stop = 1'b1;
      step();
      ctl_stop = 1'b0;
      step();
      chk("t5_idle_stop", 64'(sts_run), 64'd0);
      drain();
      chk("t5_beats", 64'(ob - ob0), 64'd4);

      // Stop and trigger on the same beat in ARM.
      ob0 = ob;
      pulse_start(0, 4);
      sti_tvalid = 1'b1; trg = 1'b1; ctl_stop = 1'b1;
      step();
      ctl_stop = 1'b0; trg = 1'b0; sti_tvalid = 1'b0;
      drain();
      chk("t5b_beats", 64'(ob - ob0), 64'd1);
      chk("t5b_trg", 64'(sts_trg), 64'd0);

      // rstn during PST with a stalled output beat.
      sti_tvalid = 1'b1; sto_tready = 1'b1;
      pulse_start(1, 8);
      step();
      trg = 1'b1; step(); trg = 1'b0;
      repeat (2) step();
      sto_tready = 1'b0;
      step();
      chk("t6_pending", 64'(sto_tvalid), 64'd1);
      ob0 = ob;
      #2 rstn = 1'b0;
      #1 chk_zero("t6_rstn");
      @(posedge clk); #1;
      step();
      rstn = 1'b1; sto_tready = 1'b1;
      repeat (4) step();
      chk("t6_no_beat", 64'(ob - ob0), 64'd0);

      // ctl_rst during PST with a stalled output beat.
      pulse_start(1, 8);
      step();
      trg = 1'b1; step(); trg = 1'b0;
      repeat (2) step();
      sto_tready = 1'b0;
      step();
      chk("t6b_pending", 64'(sto_tvalid), 64'd1);
      ob0 = ob;
      ctl_rst = 1'b1;
      step();
      ctl_rst = 1'b0;
      chk_zero("t6b_ctlrst");
      sto_tready = 1'b1;
      repeat (4) step();
      chk("t6b_no_beat", 64'(ob - ob0), 64'd0);
      drain();

      // Random mix of starts, stops, triggers and short configurations.
      for (int c = 0; c < 1500; c++) begin
         ctl_start = ($urandom_range(0, 99) < 4);
         cfg_pre = CW'($urandom_range(0, 5));
         cfg_pst = CW'($urandom_range(0, 5));
         ctl_stop = ($urandom_range(0, 99) < 2);
         trg = ($urandom_range(0, 99) < 15);
         sti_tvalid = ($urandom_range(0, 99) < 75);
         sto_tready = ($urandom_range(0, 99) < 60);
         step();
      end
      ctl_start = 1'b0; trg = 1'b0;
      ctl_stop = 1'b1; sti_tvalid = 1'b1; sto_tready = 1'b1;
      step();
      ctl_stop = 1'b0;
      wait_idle(50);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
